dbus_arbiter: RTL and testbench

//  Registered two-master data-bus arbiter. Shares the data memory and the accumulator peripheral between master 0 (CPU data port) and master 1 (DMA/test port).

---
 rtl/dbus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dbus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: registered two-master arbiter for the data bus.
// Master 0 is the CPU data port and master 1 is the DMA/test port. The arbiter
// grants one master at a time and decodes that master's address into strobes
// for the data memory and the accumulator peripheral.
//
// Handshake: a master raises mX_req and holds addr/wdata/we stable until it
// sees mX_gnt. Each cycle with mX_req & mX_gnt high completes one access. In
// that cycle, read data comes back on mX_rdata. While mX_req is high and
// mX_gnt is low, the master is stalled (mX_stall). Dropping req in a cycle
// that would have been granted is legal, and that cycle performs no access.
module dbus_arbiter #(
   parameter logic [31:0] ACC_BASE = 32'h0000_1000,
   parameter int          MAX_HOLD = 4,
   parameter int          CNT_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   input  logic [3:0]       m0_we,
   output logic             m0_gnt,
   output logic             m0_stall,
   output logic [31:0]      m0_rdata,
   input  logic             m1_req,
   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   input  logic [3:0]       m1_we,
   output logic             m1_gnt,
   output logic             m1_stall,
   output logic [31:0]      m1_rdata,
   output logic [31:0]      s_addr,
   output logic [31:0]      s_wdata,
   output logic [3:0]       dmem_we,
   output logic             acc_ce,
   output logic             acc_we,
   input  logic [31:0]      dmem_rdata,
   input  logic [31:0]      acc_rdata,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_hold_cnt,
   output logic             dbg_last
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic             last;     // last master that was given ownership

   logic             any_gnt;
   logic             is_acc;
   logic [31:0]      sel_addr;
   logic [31:0]      sel_wdata;
   logic [3:0]       sel_we;
   logic [31:0]      sel_rdata;

   // Ownership FSM. hold_cnt counts how long the owner has kept the bus while the other master waits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last     <= 1'b1;   // so master 0 wins the first tie
      end else begin
         case (state)
            IDLE: begin
               hold_cnt <= '0;
               if (m0_req && m1_req) begin
                  state <= last ? OWN0 : OWN1;
                  last  <= ~last;
               end else if (m0_req) begin
                  state <= OWN0;
                  last  <= 1'b0;
               end else if (m1_req) begin
                  state <= OWN1;
                  last  <= 1'b1;
               end
            end
            OWN0: begin
               if (!m0_req) begin
                  hold_cnt <= '0;
                  if (m1_req) begin
                     state <= OWN1;
                     last  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (!m1_req) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= OWN1;
                  hold_cnt <= '0;
                  last     <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            OWN1: begin
               if (!m1_req) begin
                  hold_cnt <= '0;
                  if (m0_req) begin
                     state <= OWN0;
                     last  <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (!m0_req) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= OWN0;
                  hold_cnt <= '0;
                  last     <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   // Grants, the granted master's request fields, and the address decode (waiting master never reaches the slaves).
   always_comb begin
      m0_gnt    = (state == OWN0) && m0_req;
      m1_gnt    = (state == OWN1) && m1_req;
      any_gnt   = m0_gnt || m1_gnt;
      sel_addr  = 32'h0;
      sel_wdata = 32'h0;
      sel_we    = 4'h0;
      if (m0_gnt) begin
         sel_addr  = m0_addr;
         sel_wdata = m0_wdata;
         sel_we    = m0_we;
      end else if (m1_gnt) begin
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
         sel_we    = m1_we;
      end
      is_acc    = any_gnt && (sel_addr[31:4] == ACC_BASE[31:4]);
      sel_rdata = is_acc ? acc_rdata : dmem_rdata;
   end

   // Slave strobes and per-master return paths. Everything is zero when no grant is active.
   always_comb begin
      s_addr   = sel_addr;
      s_wdata  = sel_wdata;
      dmem_we  = (any_gnt && !is_acc) ? sel_we : 4'h0;
      acc_ce   = is_acc;
      acc_we   = is_acc && (sel_we != 4'h0);
      m0_stall = m0_req && !m0_gnt;
      m1_stall = m1_req && !m1_gnt;
      m0_rdata = m0_gnt ? sel_rdata : 32'h0;
      m1_rdata = m1_gnt ? sel_rdata : 32'h0;
   end

   assign dbg_state    = state;
   assign dbg_hold_cnt = hold_cnt;
   assign dbg_last     = last;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed table vectors plus hand-written multi-cycle
// sequences for dbus_arbiter. A small dmem and accumulator model sit behind the slave port.
module tb_dbus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_gnt, m0_stall, m1_gnt, m1_stall;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  dmem_we;
   logic        acc_ce, acc_we;
   logic [31:0] dmem_rdata, acc_rdata;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_hold_cnt;
   logic        dbg_last;

   int n_checks = 0;
   int n_pass   = 0;

   dbus_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_gnt(m1_gnt), .m1_stall(m1_stall), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .dmem_we(dmem_we),
      .acc_ce(acc_ce), .acc_we(acc_we),
      .dmem_rdata(dmem_rdata), .acc_rdata(acc_rdata),
      .dbg_state(dbg_state), .dbg_hold_cnt(dbg_hold_cnt), .dbg_last(dbg_last)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave models: byte-enabled dmem and a 32-bit accumulator register, cleared on reset.
   logic [31:0] mem [0:63];
   logic [31:0] acc_reg;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         acc_reg <= 32'h0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (dmem_we[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
         if (acc_we) acc_reg <= s_wdata;
      end
   end
   assign dmem_rdata = mem[s_addr[7:2]];
   assign acc_rdata  = acc_reg;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One record per cycle: inputs, then the outputs expected during that cycle.
   typedef struct {
      string       name;
      logic        m0_req;
      logic [31:0] m0_addr;
      logic [31:0] m0_wdata;
      logic [3:0]  m0_we;
      logic        m1_req;
      logic [31:0] m1_addr;
      logic [31:0] m1_wdata;
      logic [3:0]  m1_we;
      logic [1:0]  e_state;
      logic [5:0]  e_ctl;    // {m0_gnt, m1_gnt, m0_stall, m1_stall, acc_ce, acc_we}
      logic [3:0]  e_dwe;
      logic [31:0] e_saddr;
      logic [31:0] e_swd;
      logic [31:0] e_r0;
      logic [31:0] e_r1;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{"idle",       1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd0, 6'b000000, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0};
      vecs[1] = '{"m0_wr_req",  1'b1, 32'h20,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd0, 6'b001000, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0};
      vecs[2] = '{"m0_wr",      1'b1, 32'h20,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd1, 6'b100000, 4'hF, 32'h20,   32'hDEADBEEF, 32'h0,        32'h0};
      vecs[3] = '{"m0_rd",      1'b1, 32'h20,   32'h11111111, 4'h0, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd1, 6'b100000, 4'h0, 32'h20,   32'h11111111, 32'hDEADBEEF, 32'h0};
      vecs[4] = '{"m1_wr_req",  1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h1004, 32'h5,        4'hF,
                  2'd1, 6'b000100, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0};
      vecs[5] = '{"m1_acc_wr",  1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h1004, 32'h5,        4'hF,
                  2'd2, 6'b010011, 4'h0, 32'h1004, 32'h5,        32'h0,        32'h0};
      vecs[6] = '{"m1_acc_rd",  1'b1, 32'h1008, 32'h33333333, 4'hF, 1'b1, 32'h1004, 32'h22222222, 4'h0,
                  2'd2, 6'b011010, 4'h0, 32'h1004, 32'h22222222, 32'h0,        32'h5};
      vecs[7] = '{"drop_all",   1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd2, 6'b000000, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0};
      vecs[8] = '{"idle_again", 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,    32'h0,        4'h0,
                  2'd0, 6'b000000, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0};

      // Reset held low for three cycles with no requests: every output stays zero.
      reset = 1'b0;
      m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_we = 4'h0;
      m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_we = 4'h0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_ctl", {22'h0, m0_gnt, m1_gnt, m0_stall, m1_stall, acc_ce, acc_we, dmem_we}, 32'h0);
         chk("rst_bus", s_addr | s_wdata | m0_rdata | m1_rdata, 32'h0);
         chk("rst_state", {30'h0, dbg_state}, 32'd0);
      end
      reset = 1'b1;
      #1;
      chk("rel_state", {30'h0, dbg_state}, 32'd0);
      chk("rel_last", {31'h0, dbg_last}, 32'd1);
      chk("rel_hold", {29'h0, dbg_hold_cnt}, 32'd0);
      step();

      // Table: single-master dmem write/read, accumulator write/read, contested decode.
      for (int i = 0; i < 9; i++) begin
         m0_req = vecs[i].m0_req; m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata; m0_we = vecs[i].m0_we;
         m1_req = vecs[i].m1_req; m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata; m1_we = vecs[i].m1_we;
         #1;
         chk({vecs[i].name, ".state"}, {30'h0, dbg_state}, {30'h0, vecs[i].e_state});
         chk({vecs[i].name, ".ctl"}, {26'h0, m0_gnt, m1_gnt, m0_stall, m1_stall, acc_ce, acc_we},
             {26'h0, vecs[i].e_ctl});
         chk({vecs[i].name, ".dmem_we"}, {28'h0, dmem_we}, {28'h0, vecs[i].e_dwe});
         chk({vecs[i].name, ".s_addr"}, s_addr, vecs[i].e_saddr);
         chk({vecs[i].name, ".s_wdata"}, s_wdata, vecs[i].e_swd);
         chk({vecs[i].name, ".m0_rdata"}, m0_rdata, vecs[i].e_r0);
         chk({vecs[i].name, ".m1_rdata"}, m1_rdata, vecs[i].e_r1);
         step();
      end

      // Fresh reset, then both masters request continuously: M0 gets 4 grants, M1 gets 4, back to M0.
      reset = 1'b0;
      #2;
      reset = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h40;   m0_wdata = 32'h0; m0_we = 4'h0;
      m1_req = 1'b1; m1_addr = 32'h1000; m1_wdata = 32'h0; m1_we = 4'h0;
      for (int i = 0; i < 10; i++) begin
         logic       eg0, eg1;
         logic [1:0] est;
         logic [2:0] ehold;
         eg0   = (i >= 1 && i <= 4) || (i == 9);
         eg1   = (i >= 5 && i <= 8);
         est   = (i == 0) ? 2'd0 : (eg1 ? 2'd2 : 2'd1);
         ehold = (i >= 1 && i <= 4) ? 3'(i - 1) : ((i >= 5 && i <= 8) ? 3'(i - 5) : 3'd0);
         #1;
         chk($sformatf("fair%0d.gnt", i), {28'h0, m0_gnt, m1_gnt, m0_stall, m1_stall},
             {28'h0, eg0, eg1, ~eg0, ~eg1});
         chk($sformatf("fair%0d.state", i), {30'h0, dbg_state}, {30'h0, est});
         chk($sformatf("fair%0d.hold", i), {29'h0, dbg_hold_cnt}, {29'h0, ehold});
         chk($sformatf("fair%0d.s_addr", i), s_addr, eg0 ? 32'h40 : (eg1 ? 32'h1000 : 32'h0));
         chk($sformatf("fair%0d.acc_ce", i), {31'h0, acc_ce}, {31'h0, eg1});
         step();
      end

      // M0 drops req while owning with M1 waiting: handover with no idle gap.
      m0_req = 1'b0;
      #1;
      chk("drop.gnt", {29'h0, m0_gnt, m1_gnt, m1_stall}, 32'b001);
      chk("drop.state", {30'h0, dbg_state}, 32'd1);
      step();
      chk("handover.state", {30'h0, dbg_state}, 32'd2);
      chk("handover.hold", {29'h0, dbg_hold_cnt}, 32'd0);
      chk("handover.gnt", {30'h0, m0_gnt, m1_gnt}, 32'b01);

      // Reset in the middle of an M1 dmem write burst: grant and strobes drop at once.
      m1_addr = 32'h30; m1_wdata = 32'hCAFEF00D; m1_we = 4'hF;
      #1;
      chk("burst.gnt", {31'h0, m1_gnt}, 32'd1);
      chk("burst.dmem_we", {28'h0, dmem_we}, 32'hF);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst.gnt", {30'h0, m0_gnt, m1_gnt}, 32'd0);
      chk("async_rst.strobes", {26'h0, acc_ce, acc_we, dmem_we}, 32'd0);
      chk("async_rst.bus", s_addr | s_wdata | m1_rdata, 32'h0);
      chk("async_rst.state", {30'h0, dbg_state}, 32'd0);
      step();
      reset = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h40; m0_we = 4'h0;
      m1_req = 1'b1;
      #1;
      chk("post_rst.state", {30'h0, dbg_state}, 32'd0);
      chk("post_rst.last", {31'h0, dbg_last}, 32'd1);
      chk("post_rst.idle_gnt", {30'h0, m0_gnt, m1_gnt}, 32'd0);
      step();
      chk("post_rst.tie", {30'h0, m0_gnt, m1_gnt}, 32'b10);
      chk("post_rst.m1_stall", {31'h0, m1_stall}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
